// File: rtl/wallace_reduce_pipe_pkg.sv
// Shared constants and types for the pipelined 32x32 Wallace-tree reduction.
// Optional macro WALLACE_SIGNED_EN selects the Baugh-Wooley signed build.
package wallace_reduce_pipe_pkg;

  localparam int unsigned WALLACE_N       = 32;
  localparam int unsigned WALLACE_W       = 64;
  localparam int unsigned WALLACE_LEVELS  = 8;
  localparam int unsigned WALLACE_LATENCY = 5;

  typedef logic [WALLACE_W-1:0] pp_row_t;

  // Rows left after one 3:2 level: two per triple plus the untouched leftovers.
  function automatic int unsigned csa_rows_out(input int unsigned n);
    return 2 * (n / 3) + (n % 3);
  endfunction

`ifdef WALLACE_SIGNED_EN
  localparam int unsigned ROWS_L0 = WALLACE_N + 1;
  // Baugh-Wooley correction constant: +2^32 and +2^63.
  localparam pp_row_t BW_CONST_ROW = (pp_row_t'(1) << 32) | (pp_row_t'(1) << 63);
`else
  localparam int unsigned ROWS_L0 = WALLACE_N;
`endif

  localparam int unsigned ROWS_L1 = csa_rows_out(ROWS_L0);
  localparam int unsigned ROWS_L2 = csa_rows_out(ROWS_L1);
  localparam int unsigned ROWS_L3 = csa_rows_out(ROWS_L2);
  localparam int unsigned ROWS_L4 = csa_rows_out(ROWS_L3);
  localparam int unsigned ROWS_L5 = csa_rows_out(ROWS_L4);
  localparam int unsigned ROWS_L6 = csa_rows_out(ROWS_L5);
  localparam int unsigned ROWS_L7 = csa_rows_out(ROWS_L6);
  localparam int unsigned ROWS_L8 = csa_rows_out(ROWS_L7);

endpackage

// File: rtl/wallace_reduce_pipe_csa_row.sv
// 64-bit 3:2 carry-save compressor row.
// Ports: x, y, z - rows to compress; s - bitwise sum; c - majority carry,
// already shifted left by one and truncated to 64 bits.
module csa_row
  import wallace_reduce_pipe_pkg::*;
(
  input  pp_row_t x,
  input  pp_row_t y,
  input  pp_row_t z,
  output pp_row_t s,
  output pp_row_t c
);

  assign s = x ^ y ^ z;
  assign c = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/wallace_reduce_pipe.sv
// Pipelined 32x32 partial-product generation and Wallace-tree reduction to two
// 64-bit carry-save rows whose sum is a*b mod 2^64. Five register stages:
// PP rows, then after CSA levels 2, 4, 6 and 8.
// Macro WALLACE_SIGNED_EN: two's-complement (Baugh-Wooley) product.
// Ports:
//   clk, clear_n     - clock, synchronous active-low clear of all stages
//   en               - pipeline advance; low freezes every register
//   in_valid, a, b, in_tag - operand pair and sideband tag
//   row_s, row_c     - carry-save result rows (row_c pre-shifted)
//   out_valid, out_tag - qualifier and tag of the pair at the output
module wallace_reduce_pipe
  import wallace_reduce_pipe_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      row_s,
  output logic [63:0]      row_c,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned MSB = WALLACE_N - 1;

  pp_row_t pp_d [ROWS_L0];
  pp_row_t pp_q [ROWS_L0];
  pp_row_t l1   [ROWS_L1];
  pp_row_t l2   [ROWS_L2];
  pp_row_t s1_q [ROWS_L2];
  pp_row_t l3   [ROWS_L3];
  pp_row_t l4   [ROWS_L4];
  pp_row_t s2_q [ROWS_L4];
  pp_row_t l5   [ROWS_L5];
  pp_row_t l6   [ROWS_L6];
  pp_row_t s3_q [ROWS_L6];
  pp_row_t l7   [ROWS_L7];
  pp_row_t l8   [ROWS_L8];

  logic [WALLACE_LATENCY-1:0] vld_q;
  logic [TAG_W-1:0]           tag_q [WALLACE_LATENCY];

  // Partial-product rows: bit a[j]&b[i] lands at weight i+j of row i.
  always_comb begin
    for (int r = 0; r < int'(ROWS_L0); r++) pp_d[r] = '0;
    for (int i = 0; i < int'(WALLACE_N); i++) begin
      for (int j = 0; j < int'(WALLACE_N); j++) begin
`ifdef WALLACE_SIGNED_EN
        // Cross terms with exactly one sign bit carry negative weight.
        pp_d[i][i+j] = (a[j] & b[i]) ^ ((i == int'(MSB)) != (j == int'(MSB)));
`else
        pp_d[i][i+j] = a[j] & b[i];
`endif
      end
    end
`ifdef WALLACE_SIGNED_EN
    pp_d[WALLACE_N] = BW_CONST_ROW;
`endif
  end

  // Level 1: PP register -> l1
  for (genvar t = 0; t < ROWS_L0 / 3; t++) begin : g_l1_csa
    csa_row u_csa (.x(pp_q[3*t]), .y(pp_q[3*t+1]), .z(pp_q[3*t+2]),
                   .s(l1[2*t]), .c(l1[2*t+1]));
  end
  for (genvar r = 0; r < ROWS_L0 % 3; r++) begin : g_l1_pass
    assign l1[2*(ROWS_L0/3)+r] = pp_q[3*(ROWS_L0/3)+r];
  end

  // Level 2: l1 -> l2 (registered into s1_q)
  for (genvar t = 0; t < ROWS_L1 / 3; t++) begin : g_l2_csa
    csa_row u_csa (.x(l1[3*t]), .y(l1[3*t+1]), .z(l1[3*t+2]),
                   .s(l2[2*t]), .c(l2[2*t+1]));
  end
  for (genvar r = 0; r < ROWS_L1 % 3; r++) begin : g_l2_pass
    assign l2[2*(ROWS_L1/3)+r] = l1[3*(ROWS_L1/3)+r];
  end

  // Level 3: s1_q -> l3
  for (genvar t = 0; t < ROWS_L2 / 3; t++) begin : g_l3_csa
    csa_row u_csa (.x(s1_q[3*t]), .y(s1_q[3*t+1]), .z(s1_q[3*t+2]),
                   .s(l3[2*t]), .c(l3[2*t+1]));
  end
  for (genvar r = 0; r < ROWS_L2 % 3; r++) begin : g_l3_pass
    assign l3[2*(ROWS_L2/3)+r] = s1_q[3*(ROWS_L2/3)+r];
  end

  // Level 4: l3 -> l4 (registered into s2_q)
  for (genvar t = 0; t < ROWS_L3 / 3; t++) begin : g_l4_csa
    csa_row u_csa (.x(l3[3*t]), .y(l3[3*t+1]), .z(l3[3*t+2]),
                   .s(l4[2*t]), .c(l4[2*t+1]));
  end
  for (genvar r = 0; r < ROWS_L3 % 3; r++) begin : g_l4_pass
    assign l4[2*(ROWS_L3/3)+r] = l3[3*(ROWS_L3/3)+r];
  end

  // Level 5: s2_q -> l5
  for (genvar t = 0; t < ROWS_L4 / 3; t++) begin : g_l5_csa
    csa_row u_csa (.x(s2_q[3*t]), .y(s2_q[3*t+1]), .z(s2_q[3*t+2]),
                   .s(l5[2*t]), .c(l5[2*t+1]));
  end
  for (genvar r = 0; r < ROWS_L4 % 3; r++) begin : g_l5_pass
    assign l5[2*(ROWS_L4/3)+r] = s2_q[3*(ROWS_L4/3)+r];
  end

  // Level 6: l5 -> l6 (registered into s3_q)
  for (genvar t = 0; t < ROWS_L5 / 3; t++) begin : g_l6_csa
    csa_row u_csa (.x(l5[3*t]), .y(l5[3*t+1]), .z(l5[3*t+2]),
                   .s(l6[2*t]), .c(l6[2*t+1]));
  end
  for (genvar r = 0; r < ROWS_L5 % 3; r++) begin : g_l6_pass
    assign l6[2*(ROWS_L5/3)+r] = l5[3*(ROWS_L5/3)+r];
  end

  // Level 7: s3_q -> l7
  for (genvar t = 0; t < ROWS_L6 / 3; t++) begin : g_l7_csa
    csa_row u_csa (.x(s3_q[3*t]), .y(s3_q[3*t+1]), .z(s3_q[3*t+2]),
                   .s(l7[2*t]), .c(l7[2*t+1]));
  end
  for (genvar r = 0; r < ROWS_L6 % 3; r++) begin : g_l7_pass
    assign l7[2*(ROWS_L6/3)+r] = s3_q[3*(ROWS_L6/3)+r];
  end

  // Level 8: l7 -> l8, the final sum/carry pair
  for (genvar t = 0; t < ROWS_L7 / 3; t++) begin : g_l8_csa
    csa_row u_csa (.x(l7[3*t]), .y(l7[3*t+1]), .z(l7[3*t+2]),
                   .s(l8[2*t]), .c(l8[2*t+1]));
  end
  for (genvar r = 0; r < ROWS_L7 % 3; r++) begin : g_l8_pass
    assign l8[2*(ROWS_L7/3)+r] = l7[3*(ROWS_L7/3)+r];
  end

  // Data pipeline registers; invalid slots advance like valid ones.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int r = 0; r < int'(ROWS_L0); r++) pp_q[r] <= '0;
      for (int r = 0; r < int'(ROWS_L2); r++) s1_q[r] <= '0;
      for (int r = 0; r < int'(ROWS_L4); r++) s2_q[r] <= '0;
      for (int r = 0; r < int'(ROWS_L6); r++) s3_q[r] <= '0;
      row_s <= '0;
      row_c <= '0;
    end else if (en) begin
      for (int r = 0; r < int'(ROWS_L0); r++) pp_q[r] <= pp_d[r];
      for (int r = 0; r < int'(ROWS_L2); r++) s1_q[r] <= l2[r];
      for (int r = 0; r < int'(ROWS_L4); r++) s2_q[r] <= l4[r];
      for (int r = 0; r < int'(ROWS_L6); r++) s3_q[r] <= l6[r];
      row_s <= l8[0];
      row_c <= l8[1];
    end
  end

  // Valid/tag shift chain matching the data latency.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      vld_q <= '0;
      for (int k = 0; k < int'(WALLACE_LATENCY); k++) tag_q[k] <= '0;
    end else if (en) begin
      vld_q    <= {vld_q[WALLACE_LATENCY-2:0], in_valid};
      tag_q[0] <= in_tag;
      for (int k = 1; k < int'(WALLACE_LATENCY); k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign out_valid = vld_q[WALLACE_LATENCY-1];
  assign out_tag   = tag_q[WALLACE_LATENCY-1];

endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// Self-checking bench for wallace_reduce_pipe (unsigned or WALLACE_SIGNED_EN build).
module tb_wallace_reduce_pipe;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             clear_n;
  logic             en;
  logic             in_valid;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [TAG_W-1:0] in_tag;
  logic [63:0]      row_s;
  logic [63:0]      row_c;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned en_cnt = 0;

  typedef struct {
    logic [63:0]      sum;
    logic [TAG_W-1:0] tag;
    int unsigned      cnt;
  } exp_t;

  exp_t sb[$];

  wallace_reduce_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .clear_n(clear_n), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .in_tag(in_tag),
    .row_s(row_s), .row_c(row_c), .out_valid(out_valid), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Enabled, non-cleared edges; used to measure latency in en-high cycles.
  always @(posedge clk) if (clear_n && en) en_cnt <= en_cnt + 1;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
`ifdef WALLACE_SIGNED_EN
    logic [63:0] xs, ys;
    xs = {{32{x[31]}}, x};
    ys = {{32{y[31]}}, y};
    return xs * ys;
`else
    return {32'h0, x} * {32'h0, y};
`endif
  endfunction

  task automatic do_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; a = '0; b = '0; in_tag = '0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; en = 1'b1;
    drive_idle();
    repeat (2) do_edge();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (row_s !== 64'h0) begin errors++; $display("FAIL reset_row_s got %h exp 0", row_s); end
    checks++; if (row_c !== 64'h0) begin errors++; $display("FAIL reset_row_c got %h exp 0", row_c); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_tag got %h exp 0", out_tag); end
    clear_n = 1'b1;
    repeat (5) do_edge();
  endtask

  // Single isolated pairs: output valid on exactly the 4th edge after the sample edge.
  task automatic test_vectors();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [63:0] exp_sum;
    va = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0003, 32'h7FFF_FFFF};
    vb = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0007, 32'h8000_0000};
    for (int k = 0; k < 6; k++) begin
      exp_sum = ref_prod(va[k], vb[k]);
      a = va[k]; b = vb[k]; in_valid = 1'b1; in_tag = TAG_W'(k + 1);
      do_edge();
      drive_idle();
      for (int c = 0; c <= 6; c++) begin
        if (c > 0) do_edge();
        checks++;
        if (out_valid !== (c == 4)) begin
          errors++; $display("FAIL vec%0d_valid_c%0d got %b exp %b", k, c, out_valid, (c == 4));
        end
        if (c == 4) begin
          checks++;
          if (row_s + row_c !== exp_sum) begin
            errors++; $display("FAIL vec%0d_sum got %h exp %h", k, row_s + row_c, exp_sum);
          end
          checks++;
          if (out_tag !== TAG_W'(k + 1)) begin
            errors++; $display("FAIL vec%0d_tag got %h exp %h", k, out_tag, TAG_W'(k + 1));
          end
`ifndef WALLACE_SIGNED_EN
          if (va[k] == 32'h0) begin
            checks++;
            if (row_s !== 64'h0 || row_c !== 64'h0) begin
              errors++; $display("FAIL vec%0d_zero_rows got %h/%h exp 0/0", k, row_s, row_c);
            end
          end
`endif
        end
      end
    end
  endtask

  // Pair in flight for 2 cycles, then en low for 3: result after 8 edges total.
  task automatic test_stall();
    logic [63:0] exp_sum;
    logic        exp_v;
    exp_sum = ref_prod(32'd3, 32'd7);
    en = 1'b1; drive_idle();
    repeat (6) do_edge();
    a = 32'd3; b = 32'd7; in_valid = 1'b1; in_tag = TAG_W'(5);
    do_edge();
    for (int c = 1; c <= 10; c++) begin
      if (c >= 3 && c <= 5) begin
        en = 1'b0;
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1; in_tag = TAG_W'(15);
      end else begin
        en = 1'b1; drive_idle();
      end
      do_edge();
      exp_v = (c == 7);
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL stall_valid_c%0d got %b exp %b", c, out_valid, exp_v);
      end
      checks++;
      if (row_s + row_c !== (exp_v ? exp_sum : 64'h0)) begin
        errors++; $display("FAIL stall_sum_c%0d got %h exp %h", c, row_s + row_c, exp_v ? exp_sum : 64'h0);
      end
      checks++;
      if (out_tag !== (exp_v ? TAG_W'(5) : TAG_W'(0))) begin
        errors++; $display("FAIL stall_tag_c%0d got %h exp %h", c, out_tag, exp_v ? TAG_W'(5) : TAG_W'(0));
      end
    end
    en = 1'b1;
  endtask

  // 1000 back-to-back random pairs through a scoreboard.
  task automatic test_back_to_back();
    exp_t e;
    en = 1'b1; drive_idle();
    sb.delete();
    for (int i = 0; i < 1000 + 10; i++) begin
      if (i < 1000) begin
        a = $urandom(); b = $urandom(); in_valid = 1'b1; in_tag = TAG_W'(i);
        e.sum = ref_prod(a, b); e.tag = TAG_W'(i); e.cnt = en_cnt + 1;
        sb.push_back(e);
      end else begin
        drive_idle();
      end
      do_edge();
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_spurious got out_valid=1 tag %h exp no output", out_tag);
        end else begin
          e = sb.pop_front();
          checks++;
          if (row_s + row_c !== e.sum) begin
            errors++; $display("FAIL stream_sum got %h exp %h", row_s + row_c, e.sum);
          end
          checks++;
          if (out_tag !== e.tag) begin
            errors++; $display("FAIL stream_tag got %h exp %h", out_tag, e.tag);
          end
          checks++;
          if (en_cnt - e.cnt !== 4) begin
            errors++; $display("FAIL stream_latency got %0d exp 4 edges after sample", en_cnt - e.cnt);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL stream_drain got %0d pending exp 0", sb.size());
    end
  endtask

  // Clear with the pipe full (and en low, which clear overrides).
  task automatic test_clear();
    en = 1'b1; drive_idle();
    repeat (6) do_edge();
    for (int i = 0; i < 5; i++) begin
      a = $urandom() | 32'h1; b = $urandom() | 32'h1; in_valid = 1'b1; in_tag = TAG_W'(i + 1);
      do_edge();
    end
    clear_n = 1'b0; en = 1'b0; drive_idle();
    do_edge();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp 0", out_valid); end
    checks++; if (row_s !== 64'h0) begin errors++; $display("FAIL clear_row_s got %h exp 0", row_s); end
    checks++; if (row_c !== 64'h0) begin errors++; $display("FAIL clear_row_c got %h exp 0", row_c); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL clear_tag got %h exp 0", out_tag); end
    clear_n = 1'b1; en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      do_edge();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL clear_ghost_c%0d got out_valid=%b tag %h exp 0", c, out_valid, out_tag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wallace_reduce_pipe.md
# wallace_reduce_pipe

Pipelined 32×32 Wallace-tree partial-product reduction stage of the pipelined multiplier. It accepts operands `a` and `b` and generates the 32 partial-product rows. It compresses those rows with 3:2 carry-save adders into two 64-bit rows whose sum is the product mod 2^64. The two rows feed directly into the pipelined 64-bit prefix adder, which produces the final product.

## Interface
- `TAG_W`, default 4: width of the sideband tag carried alongside each operand pair.
- `clk` input 1: clock; all state updates on its rising edge.
- `clear_n` input 1: reset, synchronous, active-low.
- `en` input 1: pipeline advance enable; low freezes every stage.
- `in_valid` input 1: `a`/`b`/`in_tag` hold a new operand pair.
- `a` input 32: multiplicand.
- `b` input 32: multiplier.
- `in_tag` input TAG_W: opaque sideband, returned with the result.
- `row_s` output 64: carry-save sum row.
- `row_c` output 64: carry-save carry row, already shifted left by one.
- `out_valid` output 1: `row_s`/`row_c`/`out_tag` are a valid result.
- `out_tag` output TAG_W: tag of the pair currently at the output.

## Operation
- Stage 0 (PP): `pp[i][j] = a[j] & b[i]`, placed at bit `i+j`, giving 32 rows of 64 bits, zero-extended. The rows are registered together with `in_valid` and `in_tag`.
- Reduction: 8 CSA levels. Row counts are 32→22→15→10→7→5→4→3→2.
  - Each level groups the rows in index order into triples.
  - Each triple produces `s = x^y^z` and `c = maj(x,y,z)<<1`. The carry is truncated to 64 bits.
  - Leftover 1 or 2 rows pass through unchanged.
- Registers sit after levels 2, 4, 6 and 8. The stage-4 register drives `row_s`/`row_c` directly.
- Valid and tag travel in a 5-deep shift chain alongside the data.
- Invalid slots still propagate data; only `out_valid` qualifies the outputs.
- All arithmetic is mod 2^64. Required invariant: `(row_s + row_c) mod 2^64 == a*b` (interpreted per Configuration).

## Timing
- Latency is exactly 5 `en`-high cycles from input sample to output.
  - A pair sampled at edge N appears with `out_valid=1` after edge N+4, provided `en` is high at edges N..N+4.
- Throughput is one pair per cycle; back-to-back `in_valid` is legal with no bubbles.
- `en=0`: no register changes, including the valid/tag chain. Outputs hold their values; inputs are not sampled.
- Reset is checked on every edge. `clear_n=0` forces all pipeline registers to 0, so `row_s=0`, `row_c=0`, `out_valid=0` and `out_tag=0` from the next edge.
  - Reset overrides `en`.
  - In-flight pairs are discarded and never emerge.
- First valid output after reset release requires 5 enabled cycles with valid input.
- No handshake backpressure: a downstream stall is expressed only through `en`.

## Configuration
- `WALLACE_SIGNED_EN` defined: two's-complement (Baugh-Wooley) mode.
  - Partial-product bits where exactly one of `i`, `j` equals 31 are inverted.
  - A 33rd constant row is added with bits 32 and 63 set. Row counts become 33→22→15→10→7→5→4→3→2, still 8 levels with the same latency.
  - Result is the signed product mod 2^64.
- Not defined: unsigned product, 32 rows, no constant row.
- Ports and latency are identical in both builds.

## Structure
- Shared package:
  - `WALLACE_N=32`, `WALLACE_W=64`, `WALLACE_LEVELS=8`.
  - `WALLACE_LATENCY=5`.
  - Per-level row-count constants.
  - `pp_row_t`, a 64-bit row type.
- One sub-module, `csa_row`: a 64-bit 3:2 compressor row (inputs x, y, z; outputs s, c with `c` pre-shifted). It is instantiated per triple per level.
- Pipeline registers are plain `always` blocks in the top.

## Test plan
- Unsigned build: `a=0xFFFFFFFF`, `b=0xFFFFFFFF`, `en=1`, `in_valid` for one cycle.
  - After 5 cycles: `out_valid=1` and `row_s+row_c = 0xFFFFFFFE00000001`.
  - `out_valid=0` on the cycles before and after.
- Signed build: `a=0xFFFFFFFF` (−1), `b=0xFFFFFFFF` → sum `0x0000000000000001`. Then `a=0x80000000`, `b=0x00000002` → sum `0xFFFFFFFF00000000`.
- Stream 1000 back-to-back random pairs with incrementing tags.
  - Every output sum matches the reference product.
  - Tags emerge in order with exactly 5-cycle spacing from input.
- Issue pair (`a=3`, `b=7`, tag 5). Drop `en` for 3 cycles after 2 cycles in flight.
  - Outputs frozen throughout.
  - Result (sum 21, tag 5) appears after 8 total cycles.
- Fill the pipe with 5 valid pairs, then assert `clear_n=0` for 1 cycle.
  - Next edge: `out_valid=0`, `row_s=row_c=0`.
  - None of the 5 pairs ever emerges.
- `a=0`, `b=0xDEADBEEF` → `row_s=row_c=0`. `a=1`, `b=0xDEADBEEF` → sum `0x00000000DEADBEEF`.
